skintone_v2_00_a_mask_datapath: RTL and testbench
=================================================

# skintone_v2_00_a_mask_datapath

Parametrised second-generation skin-tone datapath. It accepts packed YCbCr pixel words from the colour-converter stage and classifies every lane against a configurable Y/Cb/Cr window. Results are emitted as pass-through data or as a skin mask, under per-job opcode control, with per-job pixel and skin counters. It sits between the converter bank and the result stream, and carries its own input and output FWFT FIFOs (fifo_fwft_prog_full_count).

## Interface
- C_PIXEL_WIDTH, 8, bits per component; lane width LW = 4*C_PIXEL_WIDTH
- C_LANES, 4, pixels per word; data width DW = C_LANES*LW (128 default)
- C_FIFO_DEPTH, 512, depth of each internal FIFO (power of two, ≥ 8)
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- config_address  in  36  register index = config_address[35:4]
- config_datain  in  128  write data, low C_PIXEL_WIDTH bits used
- config_wrreq / config_rdreq  in  1  one-cycle requests
- config_wrack / config_rdack  out  1  request echoed one cycle later
- config_dataout  out  128  registered read data, zero-extended
- pixel_datain  in  DW  lane k = bits [k*LW+LW-1 : k*LW]; component order in a lane, LSB first: Y, Cb, Cr, A
- pixel_datain_valid  in  1 / pixel_datain_ready  out  1  = ~input FIFO full
- result_dataout  out  DW / result_dataout_valid  out  1 / result_dataout_ready  in  1
- opcode  in  16  [1:0] mode, [15:4] job length in words (N)
- opcode_valid  in  1 / opcode_accept  out  1
- status  out  36  see Operation

## Operation
- Config registers, C_PIXEL_WIDTH bits each, reset to 0: 0 y_min, 1 cb_min, 2 cb_max, 3 cr_min, 4 cr_max.
- Read-only config registers: 8 = job pixel count (32 bits), 9 = job skin count (32 bits).
- Writes to indices 5–15 and any index ≥ 16 are ignored. Reads of unmapped indices return 0.
- Window registers are shadow-latched at opcode accept. Writes during a job affect only the next job.
- Skin test, unsigned, inclusive: Y ≥ y_min, cb_min ≤ Cb ≤ cb_max, cr_min ≤ Cr ≤ cr_max.
- Modes:
  - 0 BYPASS: word passes unchanged.
  - 1 MASK: a skin lane outputs its input with A forced to all-ones; a non-skin lane outputs 0.
  - 2 COUNT: words are consumed and counted, nothing is written to the output FIFO.
  - 3: treated as BYPASS.
- FSM states IDLE, RUN, FLUSH.
  - IDLE: opcode_accept = opcode_valid (combinational, one cycle). On accept: latch mode, N and window; clear both counters. Go to RUN if N > 0, otherwise stay in IDLE.
  - RUN: pop the input FIFO when it is non-empty, N_rem > 0, and (output FIFO count + in-flight words) < C_FIFO_DEPTH. Decrement N_rem on each pop. Go to FLUSH on the cycle the last word pops.
  - FLUSH: wait until the pipeline is empty, then go to IDLE.
  - opcode_valid outside IDLE is held off with accept = 0.
- Input words are not consumed while IDLE; pixels may arrive ahead of an opcode.
- Pipeline: S1 registers the word and per-lane skin flags; S2 formats the output, writes the output FIFO and updates counters.
- Counters: pixel count += C_LANES and skin count += popcount(flags) per word in S2. Both saturate at 2^32−1.
- status: [0] busy (state ≠ IDLE), [2:1] latched mode, [3] input FIFO empty, [4] output FIFO empty, [5] output FIFO full, [23:6] 0, [35:24] N_rem.

## Timing
- Reset values: all acks 0, config_dataout 0, opcode_accept 0, result_dataout_valid 0, pixel_datain_ready 1, status busy = 0, state IDLE, FIFOs empty, counters 0.
- Reset mid-job aborts the job and discards both FIFO contents and in-flight words.
- Config: a request in cycle t gives its ack and read data in t+1. Back-to-back requests are supported. A write and a read to the same index in one cycle reads the old value.
- Latency: a word popped in cycle t is written to the output FIFO at the end of t+2; result_dataout_valid rises in t+3. The first pop of a job is no earlier than the cycle after accept.
- Throughput: one word per cycle when neither FIFO stalls.
- busy falls 2 cycles after the last pop; counters are final when busy = 0.
- Output backpressure never drops data. Output FIFO full must never coincide with a write.
- Input push and output pop in the same cycle are both honoured.

## Test plan
- Reset, then read registers 0–4 and 8–9 → all 0. Write y_min=0x10 at index 0, then read it back → ack after 1 cycle, data 0x10. Write index 20 → ignored, read returns 0.
- Window Y≥0x10, Cb 0x60–0x80, Cr 0x90–0xB0. Opcode mode 1, N=1. Input lanes (Y,Cb,Cr,A): (0x20,0x70,0xA0,0x00), (0x0F,0x70,0xA0,0x55), (0x20,0x80,0xB0,0x11), (0x20,0x81,0xA0,0x22). Expected: lanes 0xFFA07020, 0, 0xFFB08020, 0. Skin count 2, pixel count 4.
- Mode 0, N=300, random data, result_dataout_ready toggling 50%. Expected: 300 identical words in order, no loss, busy clears, status[35:24] = 0.
- Mode 2, N=10. Expected: no result_dataout_valid, input FIFO drained of exactly 10 words, pixel count 40.
- Push 5 words while IDLE, then send an N=3 job. Expected: exactly 3 popped and 2 remain. opcode_valid held during the job → accept only after busy = 0.
- Assert rst mid-job with both FIFOs non-empty. Expected: next cycle result_dataout_valid = 0, busy = 0, counters 0. An N=0 opcode → accepted, busy never rises, counters 0.

Source files
------------

// File: rtl/skintone_v2_00_a_mask_datapath.sv
// Skin-tone classifier datapath: input/output FWFT FIFOs, a two-stage classify/format
// pipeline, a job FSM with per-job counters, and a small config register file.

module skintone_v2_00_a_mask_datapath_fifo #(
  parameter int DW    = 128,
  parameter int DEPTH = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [DW-1:0]          din_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          dout_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: the storage array is not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module skintone_v2_00_a_mask_datapath #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_LANES       = 4,
  parameter int C_FIFO_DEPTH  = 512
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [35:0]                        config_address,
  input  logic [127:0]                       config_datain,
  input  logic                               config_wrreq,
  input  logic                               config_rdreq,
  output logic                               config_wrack,
  output logic                               config_rdack,
  output logic [127:0]                       config_dataout,
  input  logic [C_LANES*4*C_PIXEL_WIDTH-1:0] pixel_datain,
  input  logic                               pixel_datain_valid,
  output logic                               pixel_datain_ready,
  output logic [C_LANES*4*C_PIXEL_WIDTH-1:0] result_dataout,
  output logic                               result_dataout_valid,
  input  logic                               result_dataout_ready,
  input  logic [15:0]                        opcode,
  input  logic                               opcode_valid,
  output logic                               opcode_accept,
  output logic [35:0]                        status
);
  localparam int PW = C_PIXEL_WIDTH;
  localparam int LW = 4 * PW;
  localparam int DW = C_LANES * LW;
  localparam int CW = $clog2(C_FIFO_DEPTH) + 1;
  localparam logic [31:0] CNT_MAX = '1;
  localparam logic [31:0] LANES32 = 32'(C_LANES);
  localparam logic [1:0]  MODE_MASK  = 2'd1;
  localparam logic [1:0]  MODE_COUNT = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
  typedef struct packed {
    logic [PW-1:0] y_min, cb_min, cb_max, cr_min, cr_max;
  } window_t;

  state_t        state_q;
  logic [1:0]    mode_q;
  logic [11:0]   n_rem_q;
  window_t       cfg_q, win_q;
  logic          wrack_q, rdack_q;
  logic [127:0]  dataout_q, rd_data;
  logic [31:0]   cfg_idx, pix_cnt_q, skin_cnt_q, skin_inc;

  logic [DW-1:0] in_dout, out_din, fmt_d;
  logic          in_empty, in_full, out_empty, out_full, out_push, out_pop;
  logic [CW-1:0] in_count, out_count;
  logic [CW:0]   inflight;
  logic          space_ok, pop;

  logic               s1_v_q, s2_v_q;
  logic [DW-1:0]      s1_word_q, s2_word_q;
  logic [C_LANES-1:0] flags_d, s1_flags_q, s2_flags_q;

  logic unused_ok;
  assign unused_ok = ^{config_address[3:0], config_datain[127:PW], opcode[3:2], in_count};

  assign cfg_idx        = config_address[35:4];
  assign config_wrack   = wrack_q;
  assign config_rdack   = rdack_q;
  assign config_dataout = dataout_q;
  assign opcode_accept  = opcode_valid && (state_q == S_IDLE) && !rst;

  skintone_v2_00_a_mask_datapath_fifo #(.DW(DW), .DEPTH(C_FIFO_DEPTH)) u_in_fifo (
    .clk(clk), .rst(rst), .push_i(pixel_datain_valid), .din_i(pixel_datain), .pop_i(pop),
    .dout_o(in_dout), .empty_o(in_empty), .full_o(in_full), .count_o(in_count)
  );

  skintone_v2_00_a_mask_datapath_fifo #(.DW(DW), .DEPTH(C_FIFO_DEPTH)) u_out_fifo (
    .clk(clk), .rst(rst), .push_i(out_push), .din_i(out_din), .pop_i(out_pop),
    .dout_o(result_dataout), .empty_o(out_empty), .full_o(out_full), .count_o(out_count)
  );

  assign pixel_datain_ready   = !in_full;
  assign result_dataout_valid = !out_empty;
  assign out_pop  = result_dataout_ready && !out_empty;
  assign out_push = s2_v_q && (mode_q != MODE_COUNT);
  assign out_din  = s2_word_q;

  // Output space is reserved for every word still in the pipeline, so a write never meets a full FIFO.
  assign inflight = (CW+1)'(s1_v_q) + (CW+1)'(s2_v_q);
  assign space_ok = ({1'b0, out_count} + inflight) < (CW+1)'(C_FIFO_DEPTH);
  assign pop      = (state_q == S_RUN) && !in_empty && (n_rem_q != '0) && space_ok;

  assign status = {n_rem_q, 18'd0, out_full, out_empty, in_empty, mode_q, state_q != S_IDLE};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rd_data = '0;
    case (cfg_idx)
      32'd0:   rd_data[PW-1:0] = cfg_q.y_min;
      32'd1:   rd_data[PW-1:0] = cfg_q.cb_min;
      32'd2:   rd_data[PW-1:0] = cfg_q.cb_max;
      32'd3:   rd_data[PW-1:0] = cfg_q.cr_min;
      32'd4:   rd_data[PW-1:0] = cfg_q.cr_max;
      32'd8:   rd_data[31:0]   = pix_cnt_q;
      32'd9:   rd_data[31:0]   = skin_cnt_q;
      default: ;
    endcase
  end

  // NOTE: non-blocking updates mean a read in the same cycle as a write returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q     <= '0;
      wrack_q   <= 1'b0;
      rdack_q   <= 1'b0;
      dataout_q <= '0;
    end else begin
      wrack_q <= config_wrreq;
      rdack_q <= config_rdreq;
      if (config_rdreq) dataout_q <= rd_data;
      if (config_wrreq) begin
        case (cfg_idx)
          32'd0:   cfg_q.y_min  <= config_datain[PW-1:0];
          32'd1:   cfg_q.cb_min <= config_datain[PW-1:0];
          32'd2:   cfg_q.cb_max <= config_datain[PW-1:0];
          32'd3:   cfg_q.cr_min <= config_datain[PW-1:0];
          32'd4:   cfg_q.cr_max <= config_datain[PW-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      n_rem_q <= '0;
      win_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (opcode_accept) begin
          mode_q  <= opcode[1:0];
          n_rem_q <= opcode[15:4];
          win_q   <= cfg_q;
          state_q <= (opcode[15:4] != '0) ? S_RUN : S_IDLE;
        end
        S_RUN: if (pop) begin
          n_rem_q <= n_rem_q - 12'd1;
          if (n_rem_q == 12'd1) state_q <= S_FLUSH;
        end
        // Once S1 is empty, the last word leaves S2 on this edge.
        S_FLUSH: if (!s1_v_q) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    flags_d = '0;
    for (int k = 0; k < C_LANES; k++) begin
      flags_d[k] = (in_dout[k*LW +: PW] >= win_q.y_min)
                && (in_dout[k*LW+PW +: PW] >= win_q.cb_min) && (in_dout[k*LW+PW +: PW] <= win_q.cb_max)
                && (in_dout[k*LW+2*PW +: PW] >= win_q.cr_min) && (in_dout[k*LW+2*PW +: PW] <= win_q.cr_max);
    end
  end

  always_comb begin
    fmt_d = s1_word_q;
    if (mode_q == MODE_MASK) begin
      for (int k = 0; k < C_LANES; k++) begin
        fmt_d[k*LW +: LW] = s1_flags_q[k] ? {{PW{1'b1}}, s1_word_q[k*LW +: 3*PW]} : '0;
      end
    end
  end

  always_comb begin
    skin_inc = '0;
    for (int k = 0; k < C_LANES; k++) skin_inc = skin_inc + 32'(s2_flags_q[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s1_word_q  <= '0;
      s2_word_q  <= '0;
      s1_flags_q <= '0;
      s2_flags_q <= '0;
    end else begin
      s1_v_q <= pop;
      s2_v_q <= s1_v_q;
      if (pop) begin
        s1_word_q  <= in_dout;
        s1_flags_q <= flags_d;
      end
      if (s1_v_q) begin
        s2_word_q  <= fmt_d;
        s2_flags_q <= s1_flags_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || opcode_accept) begin
      pix_cnt_q  <= '0;
      skin_cnt_q <= '0;
    end else if (s2_v_q) begin
      pix_cnt_q  <= (pix_cnt_q > CNT_MAX - LANES32) ? CNT_MAX : pix_cnt_q + LANES32;
      skin_cnt_q <= (skin_cnt_q > CNT_MAX - skin_inc) ? CNT_MAX : skin_cnt_q + skin_inc;
    end
  end
endmodule

// File: tb/tb_skintone_v2_00_a_mask_datapath.sv
// Randomised self-checking bench: queue-based reference model of FIFOs, jobs and skin window.
module tb_skintone_v2_00_a_mask_datapath;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [35:0]   config_address = '0;
  logic [127:0]  config_datain = '0;
  logic          config_wrreq = 1'b0;
  logic          config_rdreq = 1'b0;
  logic          config_wrack, config_rdack;
  logic [127:0]  config_dataout;
  logic [DW-1:0] pixel_datain = '0;
  logic          pixel_datain_valid = 1'b0;
  logic          pixel_datain_ready;
  logic [DW-1:0] result_dataout;
  logic          result_dataout_valid;
  logic          result_dataout_ready = 1'b1;
  logic [15:0]   opcode = '0;
  logic          opcode_valid = 1'b0;
  logic          opcode_accept;
  logic [35:0]   status;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int  cfg_m[5] = '{0, 0, 0, 0, 0};
  int  win[5];
  int  exp_pix = 0;
  int  exp_skin = 0;
  bit  rdy_rand = 1'b0;
  bit  rdy_hold = 1'b0;

  always #5 clk = ~clk;

  skintone_v2_00_a_mask_datapath dut (
    .clk(clk), .rst(rst),
    .config_address(config_address), .config_datain(config_datain),
    .config_wrreq(config_wrreq), .config_rdreq(config_rdreq),
    .config_wrack(config_wrack), .config_rdack(config_rdack), .config_dataout(config_dataout),
    .pixel_datain(pixel_datain), .pixel_datain_valid(pixel_datain_valid),
    .pixel_datain_ready(pixel_datain_ready),
    .result_dataout(result_dataout), .result_dataout_valid(result_dataout_valid),
    .result_dataout_ready(result_dataout_ready),
    .opcode(opcode), .opcode_valid(opcode_valid), .opcode_accept(opcode_accept),
    .status(status)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && result_dataout_valid && result_dataout_ready) got_q.push_back(result_dataout);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      result_dataout_ready = rdy_hold ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit lane_is_skin(input logic [31:0] lane);
    int y, cb, cr;
    y  = int'(lane[7:0]);
    cb = int'(lane[15:8]);
    cr = int'(lane[23:16]);
    return (y >= win[0]) && (cb >= win[1]) && (cb <= win[2]) && (cr >= win[3]) && (cr <= win[4]);
  endfunction

  function automatic logic [DW-1:0] rand_word(input bit near);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      if (near)
        w[32*k +: 32] = {8'($urandom), 8'($urandom_range(8'h88, 8'hB8)),
                         8'($urandom_range(8'h58, 8'h88)), 8'($urandom_range(0, 64))};
      else
        w[32*k +: 32] = $urandom;
    end
    return w;
  endfunction

  task automatic model_job(input int mode, input int n);
    win = cfg_m;
    exp_pix = 0;
    exp_skin = 0;
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w, o;
      if (in_q.size() == 0) break;
      w = in_q.pop_front();
      o = '0;
      for (int k = 0; k < 4; k++) begin
        logic [31:0] lane;
        lane = w[32*k +: 32];
        if (lane_is_skin(lane)) begin
          exp_skin++;
          o[32*k +: 32] = {8'hFF, lane[23:0]};
        end
      end
      exp_pix += 4;
      if (mode == 1) exp_q.push_back(o);
      else if (mode != 2) exp_q.push_back(w);
    end
  endtask

  task automatic cfg_write(input int idx, input logic [127:0] d);
    config_address = {idx[31:0], 4'h0};
    config_datain  = d;
    config_wrreq   = 1'b1;
    tick();
    config_wrreq = 1'b0;
    check($sformatf("wrack_%0d", idx), config_wrack, 1);
    if (idx >= 0 && idx < 5) cfg_m[idx] = int'(d[7:0]);
  endtask

  task automatic cfg_read_check(input int idx, input logic [127:0] exp, input string tag);
    config_address = {idx[31:0], 4'h0};
    config_rdreq   = 1'b1;
    tick();
    config_rdreq = 1'b0;
    check({tag, "_rdack"}, config_rdack, 1);
    check(tag, config_dataout, exp);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    pixel_datain = w;
    pixel_datain_valid = 1'b1;
    @(negedge clk);
    if (pixel_datain_ready) in_q.push_back(w);
    tick();
    pixel_datain_valid = 1'b0;
  endtask

  task automatic send_opcode(input int mode, input int n);
    bit ok;
    ok = 1'b0;
    opcode = {n[11:0], 2'b00, mode[1:0]};
    opcode_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (opcode_accept) begin
        ok = 1'b1;
        check("accept_while_idle", status[0], 0);
        break;
      end
    end
    tick();
    opcode_valid = 1'b0;
    check("opcode_accepted", ok, 1);
    if (ok) model_job(mode, n);
  endtask

  task automatic finish_job(input string tag);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!status[0] && got_q.size() == exp_q.size()) break;
    end
    check({tag, "_done"}, i < 2000, 1);
    repeat (4) @(negedge clk);
    check({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("%s_w%0d", tag, k), got_q[k], exp_q[k]);
    check({tag, "_nrem"}, status[35:24], 0);
    got_q.delete();
    exp_q.delete();
    tick();
    cfg_read_check(8, exp_pix, {tag, "_pixcnt"});
    cfg_read_check(9, exp_skin, {tag, "_skincnt"});
  endtask

  initial begin
    int ro_idx[7] = '{0, 1, 2, 3, 4, 8, 9};
    int lat;
    bit rose;

    repeat (3) tick();
    rst = 1'b0;
    check("rst_wrack", config_wrack, 0);
    check("rst_rdack", config_rdack, 0);
    check("rst_dataout", config_dataout, 0);
    check("rst_accept", opcode_accept, 0);
    check("rst_valid", result_dataout_valid, 0);
    check("rst_ready", pixel_datain_ready, 1);
    check("rst_status", status, 36'h18);

    foreach (ro_idx[i]) cfg_read_check(ro_idx[i], 0, $sformatf("rst_reg%0d", ro_idx[i]));

    cfg_write(0, 128'h10);
    cfg_read_check(0, 128'h10, "ymin_rb");
    cfg_write(20, 128'hAB);
    cfg_read_check(20, 0, "reg20_ignored");
    cfg_write(5, 128'h33);
    cfg_read_check(5, 0, "reg5_ignored");

    config_address = {32'd1, 4'h0};
    config_datain  = 128'h60;
    config_wrreq   = 1'b1;
    config_rdreq   = 1'b1;
    tick();
    config_wrreq = 1'b0;
    config_rdreq = 1'b0;
    check("rw_same_wrack", config_wrack, 1);
    check("rw_same_old", config_dataout, 0);
    cfg_m[1] = 'h60;
    cfg_read_check(1, 128'h60, "cbmin_rb");
    cfg_write(2, 128'h80);
    cfg_write(3, 128'h90);
    cfg_write(4, 128'hB0);

    push_word({32'h22A08120, 32'h11B08020, 32'h55A0700F, 32'h00A07020});
    send_opcode(1, 1);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (result_dataout_valid) break;
      lat++;
    end
    check("mask_latency", lat, 3);
    check("mask_spec_word", result_dataout, 128'h00000000_FFB08020_00000000_FFA07020);
    tick();
    finish_job("mask_spec");

    for (int i = 0; i < 40; i++) push_word(rand_word(1'b1));
    send_opcode(1, 40);
    finish_job("mask_rand");

    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) push_word(rand_word($urandom_range(0, 1) == 1));
    send_opcode(0, 300);
    cfg_write(0, 128'h30);
    finish_job("bypass300");
    rdy_rand = 1'b0;

    for (int i = 0; i < 5; i++) push_word(rand_word(1'b1));
    send_opcode(3, 5);
    finish_job("mode3");

    for (int i = 0; i < 12; i++) push_word(rand_word(1'b1));
    send_opcode(2, 10);
    finish_job("count");
    check("count_leftover", status[3], 0);
    send_opcode(0, 2);
    finish_job("leftover");
    check("leftover_empty", status[3], 1);

    for (int i = 0; i < 5; i++) push_word(rand_word(1'b0));
    send_opcode(0, 3);
    send_opcode(0, 2);
    finish_job("holdoff");
    check("holdoff_empty", status[3], 1);

    rdy_hold = 1'b1;
    for (int i = 0; i < 20; i++) push_word(rand_word(1'b1));
    send_opcode(0, 20);
    repeat (10) tick();
    check("pre_rst_in_busy", status[3], 0);
    check("pre_rst_out_busy", status[4], 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rdy_hold = 1'b0;
    in_q.delete();
    exp_q.delete();
    got_q.delete();
    cfg_m = '{0, 0, 0, 0, 0};
    check("midrst_valid", result_dataout_valid, 0);
    check("midrst_busy", status[0], 0);
    check("midrst_status", status, 36'h18);
    cfg_read_check(8, 0, "midrst_pixcnt");
    cfg_read_check(9, 0, "midrst_skincnt");
    cfg_read_check(0, 0, "midrst_ymin");

    send_opcode(1, 0);
    rose = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (status[0]) rose = 1'b1;
    end
    check("n0_busy_never", rose, 0);
    check("n0_mode", status[2:1], 1);
    check("n0_no_output", got_q.size(), 0);
    tick();
    cfg_read_check(8, 0, "n0_pixcnt");
    cfg_read_check(9, 0, "n0_skincnt");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
